// File: rtl/pixel_csc_pkg.sv
// -----------------------------------------------------------------------------
// csc_pkg
// Shared definitions for the pixel colour-space converter:
//   - csc_mode_e   : luma coefficient set selected per pixel
//   - rgb_t        : one expanded 8-bit-per-channel RGB pixel
//   - luma_coef_t  : R/G/B luma weights, fractions of 256
//   - accumulator widths, rounding bias and chroma constants
//   - luma_coef()  : mode -> luma weights lookup
// -----------------------------------------------------------------------------
package csc_pkg;

    localparam int PIX_W      = 8;
    localparam int FRAC_BITS  = 8;    // coefficients are fractions of 2**FRAC_BITS
    localparam int ROUND_BIAS = 128;  // half an LSB after the >> FRAC_BITS
    localparam int Y_ACC_W    = 18;
    localparam int C_ACC_W    = 19;
    localparam int CHROMA_MID = 128;

    typedef enum logic [1:0] {
        MODE_BT601 = 2'd0,
        MODE_BT709 = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_GREEN = 2'd3
    } csc_mode_e;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [8:0] r;
        logic [8:0] g;
        logic [8:0] b;
    } luma_coef_t;

    localparam luma_coef_t COEF_BT601 = '{r: 9'd77, g: 9'd150, b: 9'd29};
    localparam luma_coef_t COEF_BT709 = '{r: 9'd54, g: 9'd183, b: 9'd19};
    localparam luma_coef_t COEF_AVG   = '{r: 9'd85, g: 9'd86,  b: 9'd85};
    localparam luma_coef_t COEF_GREEN = '{r: 9'd0,  g: 9'd256, b: 9'd0};

    // BT.601 chroma weights (signed, fractions of 256)
    localparam int CB_R = -43;
    localparam int CB_G = -85;
    localparam int CB_B = 128;
    localparam int CR_R = 128;
    localparam int CR_G = -107;
    localparam int CR_B = -21;

    function automatic luma_coef_t luma_coef(input csc_mode_e mode);
        luma_coef_t c;
        case (mode)
            MODE_BT601: c = COEF_BT601;
            MODE_BT709: c = COEF_BT709;
            MODE_AVG:   c = COEF_AVG;
            default:    c = COEF_GREEN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pixel_csc_if.sv
// -----------------------------------------------------------------------------
// pixel_csc_if
// Pixel stream bundle for pixel_csc: input stream (valid/ready, din, sof, eol,
// mode), output stream (valid/ready, y/cb/cr, sof, eol) and the frame counter.
//   modport master : pixel source / sink side (drives inputs, takes results)
//   modport slave  : the converter itself
// -----------------------------------------------------------------------------
interface pixel_csc_if;

    logic        in_valid;
    logic        in_ready;
    logic [23:0] din;
    logic        in_sof;
    logic        in_eol;
    logic [1:0]  mode;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y_out;
    logic [7:0]  cb_out;
    logic [7:0]  cr_out;
    logic        out_sof;
    logic        out_eol;
    logic [15:0] frame_cnt;

    modport master (
        output in_valid, din, in_sof, in_eol, mode, out_ready,
        input  in_ready, out_valid, y_out, cb_out, cr_out, out_sof, out_eol, frame_cnt
    );

    modport slave (
        input  in_valid, din, in_sof, in_eol, mode, out_ready,
        output in_ready, out_valid, y_out, cb_out, cr_out, out_sof, out_eol, frame_cnt
    );

endinterface

// File: rtl/csc_mac3.sv
// -----------------------------------------------------------------------------
// csc_mac3
// Two-stage three-term multiply-add: stage 1 registers the three products
// pix.{r,g,b} * k_{r,g,b}; stage 2 sums them with a rounding bias, shifts
// right by FRAC_BITS (arithmetic), adds OFFSET and clamps to 0..255.
//   clk, rst : clock, synchronous active-high reset
//   i_en     : advance both stages (pipeline holds when low)
//   i_pix    : unsigned 8-bit R/G/B
//   i_k_*    : signed coefficients, fractions of 256
//   o_res    : registered clamped result
// -----------------------------------------------------------------------------
module csc_mac3
    import csc_pkg::*;
#(
    parameter int COEF_W = 9,
    parameter int ACC_W  = Y_ACC_W,
    parameter int OFFSET = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  rgb_t                     i_pix,
    input  logic signed [COEF_W:0]   i_k_r,
    input  logic signed [COEF_W:0]   i_k_g,
    input  logic signed [COEF_W:0]   i_k_b,
    output logic [PIX_W-1:0]         o_res
);

    // Signed (pixel + sign bit) x signed coefficient
    localparam int PROD_W = PIX_W + COEF_W + 2;

    logic signed [PROD_W-1:0] w_p_r, w_p_g, w_p_b;
    logic signed [PROD_W-1:0] r_p_r, r_p_g, r_p_b;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_scaled;
    logic [PIX_W-1:0]         w_clamped;
    logic [PIX_W-1:0]         r_res;

    assign w_p_r = PROD_W'($signed({1'b0, i_pix.r})) * PROD_W'(i_k_r);
    assign w_p_g = PROD_W'($signed({1'b0, i_pix.g})) * PROD_W'(i_k_g);
    assign w_p_b = PROD_W'($signed({1'b0, i_pix.b})) * PROD_W'(i_k_b);

    assign w_sum    = ACC_W'(r_p_r) + ACC_W'(r_p_g) + ACC_W'(r_p_b) + ACC_W'(ROUND_BIAS);
    assign w_scaled = (w_sum >>> FRAC_BITS) + ACC_W'(OFFSET);

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        w_clamped = w_scaled[PIX_W-1:0];
        if (w_scaled[ACC_W-1]) begin
            w_clamped = '0;
        end else if (|w_scaled[ACC_W-2:PIX_W]) begin
            w_clamped = '1;
        end
    end

    // NOTE: datapath registers are reset as well, because the results must read 0 during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_p_r <= '0;
            r_p_g <= '0;
            r_p_b <= '0;
            r_res <= '0;
        end else if (i_en) begin
            r_p_r <= w_p_r;
            r_p_g <= w_p_g;
            r_p_b <= w_p_b;
            r_res <= w_clamped;
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/pixel_csc.sv
// -----------------------------------------------------------------------------
// pixel_csc
// Three-stage RGB -> Y (optionally YCbCr) converter with valid/ready flow.
//   S1: expand RGB565/RGB888 to 8-bit RGB, register with mode/sof/eol
//   S2: multiply (inside csc_mac3)
//   S3: sum, round, saturate (inside csc_mac3); registered outputs
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, flushes the pipeline
//   bus  : pixel_csc_if.slave (in/out pixel streams, frame_cnt)
// Parameters:
//   IN_FMT : 0 = RGB565 in din[15:0], 1 = RGB888 in din[23:0]
//   COEF_W : unsigned coefficient width (>= 9)
// Build option:
//   PIXEL_CSC_YCBCR_EN : when defined, cb_out/cr_out carry BT.601 chroma;
//                        otherwise they are a constant 128 (0 during reset).
// -----------------------------------------------------------------------------
module pixel_csc
    import csc_pkg::*;
#(
    parameter int IN_FMT = 0,
    parameter int COEF_W = 9
) (
    input  logic        clk,
    input  logic        rst,
    pixel_csc_if.slave  bus
);

    localparam int KW = COEF_W + 1;

    logic                  w_adv;
    rgb_t                  w_rgb;
    luma_coef_t            w_kc;
    logic signed [KW-1:0]  w_ky_r, w_ky_g, w_ky_b;
    logic [PIX_W-1:0]      w_y;

    rgb_t                  r_rgb1;
    csc_mode_e             r_mode1;
    logic                  r_v1, r_sof1, r_eol1;
    logic                  r_v2, r_sof2, r_eol2;
    logic                  r_out_valid, r_out_sof, r_out_eol;
    logic [15:0]           r_frame_cnt;
    logic                  r_sof_seen;

    // All stages move together; a stalled output freezes the whole pipe.
    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = !rst && w_adv;

    // Input expansion: RGB565 channels are widened by MSB replication.
    always_comb begin
        w_rgb = bus.din;
        if (IN_FMT == 0) begin
            w_rgb.r = {bus.din[15:11], bus.din[15:13]};
            w_rgb.g = {bus.din[10:5],  bus.din[10:9]};
            w_rgb.b = {bus.din[4:0],   bus.din[4:2]};
        end
    end

    // S1 register; sof/eol are qualified with valid so bubbles carry no markers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_rgb1  <= '0;
            r_mode1 <= MODE_BT601;
            r_sof1  <= 1'b0;
            r_eol1  <= 1'b0;
        end else if (w_adv) begin
            r_v1    <= bus.in_valid;
            r_rgb1  <= w_rgb;
            r_mode1 <= csc_mode_e'(bus.mode);
            r_sof1  <= bus.in_valid && bus.in_sof;
            r_eol1  <= bus.in_valid && bus.in_eol;
        end
    end

    // S2/S3 control shadows the two register stages inside csc_mac3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2        <= 1'b0;
            r_sof2      <= 1'b0;
            r_eol2      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
        end else if (w_adv) begin
            r_v2        <= r_v1;
            r_sof2      <= r_sof1;
            r_eol2      <= r_eol1;
            r_out_valid <= r_v2;
            r_out_sof   <= r_sof2;
            r_out_eol   <= r_eol2;
        end
    end

    // The mode sampled with the pixel picks the weights at the multiply stage.
    assign w_kc   = luma_coef(r_mode1);
    assign w_ky_r = KW'($signed({1'b0, w_kc.r}));
    assign w_ky_g = KW'($signed({1'b0, w_kc.g}));
    assign w_ky_b = KW'($signed({1'b0, w_kc.b}));

    csc_mac3 #(
        .COEF_W (COEF_W),
        .ACC_W  (Y_ACC_W),
        .OFFSET (0)
    ) u_mac_y (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_adv),
        .i_pix (r_rgb1),
        .i_k_r (w_ky_r),
        .i_k_g (w_ky_g),
        .i_k_b (w_ky_b),
        .o_res (w_y)
    );

`ifdef PIXEL_CSC_YCBCR_EN
    logic [PIX_W-1:0] w_cb, w_cr;

    csc_mac3 #(
        .COEF_W (COEF_W),
        .ACC_W  (C_ACC_W),
        .OFFSET (CHROMA_MID)
    ) u_mac_cb (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_adv),
        .i_pix (r_rgb1),
        .i_k_r (KW'(CB_R)),
        .i_k_g (KW'(CB_G)),
        .i_k_b (KW'(CB_B)),
        .o_res (w_cb)
    );

    csc_mac3 #(
        .COEF_W (COEF_W),
        .ACC_W  (C_ACC_W),
        .OFFSET (CHROMA_MID)
    ) u_mac_cr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_adv),
        .i_pix (r_rgb1),
        .i_k_r (KW'(CR_R)),
        .i_k_g (KW'(CR_G)),
        .i_k_b (KW'(CR_B)),
        .o_res (w_cr)
    );

    assign bus.cb_out = w_cb;
    assign bus.cr_out = w_cr;
`else
    assign bus.cb_out = rst ? 8'd0 : 8'(CHROMA_MID);
    assign bus.cr_out = rst ? 8'd0 : 8'(CHROMA_MID);
`endif

    // Frame counter: counts sof pixels actually handed off downstream; the
    // first one after reset opens frame 0 and is not a completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_sof_seen  <= 1'b0;
        end else if (r_out_valid && bus.out_ready && r_out_sof) begin
            if (r_sof_seen) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_sof_seen <= 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.y_out     = w_y;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eol   = r_out_eol;
    assign bus.frame_cnt = r_frame_cnt;

endmodule
